ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the RISC-V core, directly downstream of the ALU decoder.
- Consumes the 3-bit ALU control code together with the operands and destination info from decode.
- Computes the ALU result and registers it into the EX/MEM boundary with valid/ready flow control.
- Holds a one-entry skid buffer so upstream never sees a combinational path from out_ready_i.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, destination register index width

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid_i  input  1  upstream presents an operation
- in_ready_o  output  1  stage can accept an operation this cycle
- ALUControl_i  input  3  ALU operation code from ALU decoder
- SrcA_i  input  DATA_WIDTH  operand A
- SrcB_i  input  DATA_WIDTH  operand B
- Rd_i  input  REG_ADDR_WIDTH  destination register
- RegWrite_i  input  1  writeback enable
- flush_i  input  1  discard all held and incoming operations
- out_valid_o  output  1  result register holds a valid operation
- out_ready_i  input  1  downstream accepts the result
- ALUResult_o  output  DATA_WIDTH  registered result
- Zero_o  output  1  ALUResult_o == 0
- Rd_o  output  REG_ADDR_WIDTH  registered destination
- RegWrite_o  output  1  registered writeback enable
- Illegal_o  output  1  registered: op code was unsupported

Behaviour:
- Opcodes:
  - 000 add; 001 sub (A - B); 010 and; 011 or.
  - 101 slt: signed compare, result 1 when A < B, else 0, zero-extended.
  - Any other code: result 0, Illegal=1, RegWrite forced 0.
- Arithmetic wraps modulo 2^DATA_WIDTH; no overflow flag.
- Zero is computed from the computed result and registered alongside it.
- Storage: output register OUT (valid bit + payload) and skid register SKID (valid bit + computed payload).
- in_ready_o = !SKID.valid, driven from a register only. It has no combinational dependence on out_ready_i or in_valid_i.
- Input fire = in_valid_i && in_ready_o. Output fire = out_valid_o && out_ready_i.
- Each rising edge, in priority order:
  1. flush_i=1: OUT.valid<=0 and SKID.valid<=0. Any input firing that cycle is discarded. Payload registers are don't-care.
  2. OUT empty or output fire: OUT loads SKID if SKID.valid (SKID.valid<=0; a concurrent input fire is then impossible since in_ready_o=0). Otherwise OUT loads the input if input fire. Otherwise OUT.valid<=0.
  3. OUT full and not draining, and input fire: SKID captures the computed input, SKID.valid<=1.
- Latency: an accepted op appears at out_valid_o on the next cycle when not stalled.
- Throughput: 1 op/cycle while out_ready_i=1.
- Order is preserved: SKID always drains before new input reaches OUT.
- An op is never dropped or duplicated except by flush.
- While out_valid_o=1 and out_ready_i=0, all out payload outputs hold stable.
- Reset: rst_n low immediately (asynchronously) forces:
  - out_valid_o=0, SKID.valid=0, in_ready_o=1;
  - ALUResult_o=0, Zero_o=0, Rd_o=0, RegWrite_o=0, Illegal_o=0.
- Reset mid-operation discards OUT and SKID contents. The first edge after deassertion behaves as from empty.
- Simultaneous flush_i and out_ready_i: the flushed OUT entry is not counted as consumed. Downstream must ignore it; flush has priority.

Test Plan:
- Reset: hold rst_n=0 mid-stream with OUT and SKID full -> out_valid_o=0 and in_ready_o=1 immediately, all payload outputs 0. After release, a single add 3+4 appears one cycle later: ALUResult_o=7, Zero_o=0.
- Back-to-back, out_ready_i=1: add 5+5, sub 5-5, and 0xF0&0x3C, or 0xF0|0x0F on consecutive cycles -> results 10, 0 (Zero_o=1), 0x30, 0xFF on four consecutive cycles, in_ready_o constantly 1.
- Backpressure: out_ready_i=0 while sending add 1+1 then add 2+2 -> OUT holds 2, SKID holds 4, in_ready_o=0 next cycle. Raise out_ready_i -> outputs 2 then 4 in order, in_ready_o returns to 1.
- Wrap and slt: sub 0-1 -> 0xFFFFFFFF. slt A=0xFFFFFFFF, B=1 -> 1. slt A=1, B=0xFFFFFFFF -> 0.
- Illegal: ALUControl_i=111 with RegWrite_i=1 -> Illegal_o=1, RegWrite_o=0, ALUResult_o=0, Zero_o=1.
- Flush: with OUT and SKID full and in_valid_i=1, assert flush_i for one cycle -> next cycle out_valid_o=0, in_ready_o=1, and neither held op nor incoming op ever appears at the output.

Source files
------------

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage of the RISC-V core.
//
// Computes the ALU result for the operation presented by decode and registers
// it into the EX/MEM boundary with valid/ready flow control. A one-entry skid
// buffer sits behind the output register so that in_ready_o comes straight
// from a flop and never depends combinationally on out_ready_i.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake
//   ALUControl_i         3-bit ALU operation code from the ALU decoder
//   SrcA_i, SrcB_i       operands
//   Rd_i, RegWrite_i     destination register and writeback enable
//   flush_i              drop everything held and anything arriving this cycle
//   out_valid_o/out_ready_i  downstream handshake
//   ALUResult_o, Zero_o, Rd_o, RegWrite_o, Illegal_o  registered payload
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [2:0]                ALUControl_i,
    input  logic [DATA_WIDTH-1:0]     SrcA_i,
    input  logic [DATA_WIDTH-1:0]     SrcB_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_i,
    input  logic                      RegWrite_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     ALUResult_o,
    output logic                      Zero_o,
    output logic [REG_ADDR_WIDTH-1:0] Rd_o,
    output logic                      RegWrite_o,
    output logic                      Illegal_o
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic                      zero;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      illegal;
    } payload_t;

    payload_t comp;      // payload computed from the current inputs
    payload_t out_q;
    payload_t skid_q;
    logic     out_valid;
    logic     skid_valid;
    logic     in_fire;
    logic     out_drain;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        comp           = '0;
        comp.rd        = Rd_i;
        comp.reg_write = RegWrite_i;
        case (ALUControl_i)
            OP_ADD: comp.result = SrcA_i + SrcB_i;
            OP_SUB: comp.result = SrcA_i - SrcB_i;
            OP_AND: comp.result = SrcA_i & SrcB_i;
            OP_OR:  comp.result = SrcA_i | SrcB_i;
            OP_SLT: comp.result = {{(DATA_WIDTH-1){1'b0}},
                                   ($signed(SrcA_i) < $signed(SrcB_i))};
            default: begin
                // Unsupported code: result stays 0 and writeback is suppressed.
                comp.illegal   = 1'b1;
                comp.reg_write = 1'b0;
            end
        endcase
        comp.zero = (comp.result == '0);
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready is a pure function of the skid flop: upstream sees no path
    // from out_ready_i or in_valid_i.
    assign in_ready_o = !skid_valid;
    assign in_fire    = in_valid_i && in_ready_o;
    // OUT can take a new entry when it is empty or being consumed.
    assign out_drain  = !out_valid || out_ready_i;

    // ------------------------------------------------------------------
    // Valid bits and output payload
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
        end else if (flush_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_drain) begin
            if (skid_valid) begin
                // Skid is older than anything upstream; it goes first.
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_q     <= comp;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // OUT is stalled: park the accepted op in the skid slot.
            skid_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload is qualified by skid_valid and is never
    // observed while empty, so it is left out of reset; only the OUT
    // payload is reset because it drives the module outputs.
    always_ff @(posedge clk) begin
        if (!out_drain && in_fire) begin
            skid_q <= comp;
        end
    end

    assign out_valid_o = out_valid;
    assign ALUResult_o = out_q.result;
    assign Zero_o      = out_q.zero;
    assign Rd_o        = out_q.rd;
    assign RegWrite_o  = out_q.reg_write;
    assign Illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
//
// The reference model treats the stage as an in-order queue of at most two
// operations: the head is what the output must show, ready is "fewer than two
// held", an output fire pops the head and an input fire pushes the computed
// result. Directed scenarios are followed by a long randomized run.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2:0]    ALUControl_i;
    logic [DW-1:0] SrcA_i;
    logic [DW-1:0] SrcB_i;
    logic [RW-1:0] Rd_i;
    logic          RegWrite_i;
    logic          flush_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] ALUResult_o;
    logic          Zero_o;
    logic [RW-1:0] Rd_o;
    logic          RegWrite_o;
    logic          Illegal_o;

    ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .ALUControl_i (ALUControl_i),
        .SrcA_i       (SrcA_i),
        .SrcB_i       (SrcB_i),
        .Rd_i         (Rd_i),
        .RegWrite_i   (RegWrite_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .ALUResult_o  (ALUResult_o),
        .Zero_o       (Zero_o),
        .Rd_o         (Rd_o),
        .RegWrite_o   (RegWrite_o),
        .Illegal_o    (Illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic          zero;
        logic [RW-1:0] rd;
        logic          rw;
        logic          ill;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Operation semantics in plain integer arithmetic.
    function automatic exp_t model_op(input logic [2:0] c, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b, input logic [RW-1:0] rd,
                                      input logic rw);
        exp_t    e;
        longint  wide;
        longint  mask;
        mask   = (longint'(1) << DW) - 1;
        e.rd   = rd;
        e.rw   = rw;
        e.ill  = 1'b0;
        e.res  = '0;
        if (c == 3'd0) begin
            wide  = longint'(a) + longint'(b);
            e.res = DW'(wide & mask);
        end else if (c == 3'd1) begin
            wide  = longint'(a) - longint'(b) + (mask + 1);
            e.res = DW'(wide & mask);
        end else if (c == 3'd2) begin
            e.res = a & b;
        end else if (c == 3'd3) begin
            e.res = a | b;
        end else if (c == 3'd5) begin
            e.res = (int'(a) < int'(b)) ? 1 : 0;
        end else begin
            e.ill = 1'b1;
            e.rw  = 1'b0;
        end
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic compare_out();
        check("out_valid", out_valid_o, q.size() > 0);
        if (q.size() > 0) begin
            check("result",    ALUResult_o, q[0].res);
            check("zero",      Zero_o,      q[0].zero);
            check("rd",        Rd_o,        q[0].rd);
            check("reg_write", RegWrite_o,  q[0].rw);
            check("illegal",   Illegal_o,   q[0].ill);
        end
    endtask

    // One clock cycle: drive inputs just after a falling edge, check ready,
    // advance the model across the rising edge, check outputs on the next
    // falling edge.
    task automatic step(input logic v, input logic [2:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] rd, input logic rw,
                        input logic fl, input logic ordy);
        exp_t e;
        bit   in_fire;
        bit   out_fire;
        in_valid_i   = v;
        ALUControl_i = c;
        SrcA_i       = a;
        SrcB_i       = b;
        Rd_i         = rd;
        RegWrite_i   = rw;
        flush_i      = fl;
        out_ready_i  = ordy;
        #1;
        check("in_ready", in_ready_o, q.size() < 2);
        in_fire  = v && (q.size() < 2);
        out_fire = (q.size() > 0) && ordy;
        e        = model_op(c, a, b, rd, rw);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire)  q.push_back(e);
        end
        @(negedge clk);
        compare_out();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid_o, 1'b0);
        check({tag, "_in_ready"},  in_ready_o,  1'b1);
        check({tag, "_result"},    ALUResult_o, '0);
        check({tag, "_zero"},      Zero_o,      1'b0);
        check({tag, "_rd"},        Rd_o,        '0);
        check({tag, "_reg_write"}, RegWrite_o,  1'b0);
        check({tag, "_illegal"},   Illegal_o,   1'b0);
    endtask

    initial begin
        logic [DW-1:0] ops_a;
        logic [DW-1:0] ops_b;
        logic [DW-1:0] corner [4];

        rst_n        = 1'b0;
        in_valid_i   = 1'b0;
        ALUControl_i = '0;
        SrcA_i       = '0;
        SrcB_i       = '0;
        Rd_i         = '0;
        RegWrite_i   = 1'b0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b0;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-stream with OUT and SKID full.
        step(1'b1, 3'd0, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd2, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0);
        check("full_in_ready", in_ready_o, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd0, 32'd3, 32'd4, 5'd3, 1'b1, 1'b0, 1'b1);
        check("add_3_4", ALUResult_o, 32'd7);
        check("add_3_4_zero", Zero_o, 1'b0);
        idle(1'b1);

        // Back-to-back with the output always ready.
        step(1'b1, 3'd0, 32'd5,    32'd5,    5'd4, 1'b1, 1'b0, 1'b1);
        check("b2b_add", ALUResult_o, 32'd10);
        step(1'b1, 3'd1, 32'd5,    32'd5,    5'd5, 1'b1, 1'b0, 1'b1);
        check("b2b_sub", ALUResult_o, 32'd0);
        check("b2b_sub_zero", Zero_o, 1'b1);
        step(1'b1, 3'd2, 32'hF0,   32'h3C,   5'd6, 1'b1, 1'b0, 1'b1);
        check("b2b_and", ALUResult_o, 32'h30);
        step(1'b1, 3'd3, 32'hF0,   32'h0F,   5'd7, 1'b1, 1'b0, 1'b1);
        check("b2b_or", ALUResult_o, 32'hFF);
        idle(1'b1);

        // Backpressure fills OUT then SKID, then drains in order.
        step(1'b1, 3'd0, 32'd1, 32'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd2, 32'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        check("bp_hold", ALUResult_o, 32'd2);
        check("bp_ready", in_ready_o, 1'b0);
        idle(1'b0);
        check("bp_stable", ALUResult_o, 32'd2);
        idle(1'b1);
        check("bp_second", ALUResult_o, 32'd4);
        idle(1'b1);
        check("bp_ready_back", in_ready_o, 1'b1);

        // Wrap-around and signed compare.
        step(1'b1, 3'd1, 32'd0,          32'd1,          5'd10, 1'b1, 1'b0, 1'b1);
        check("wrap_sub", ALUResult_o, 32'hFFFF_FFFF);
        step(1'b1, 3'd5, 32'hFFFF_FFFF,  32'd1,          5'd11, 1'b1, 1'b0, 1'b1);
        check("slt_neg", ALUResult_o, 32'd1);
        step(1'b1, 3'd5, 32'd1,          32'hFFFF_FFFF,  5'd12, 1'b1, 1'b0, 1'b1);
        check("slt_pos", ALUResult_o, 32'd0);

        // Illegal code suppresses writeback.
        step(1'b1, 3'd7, 32'd9, 32'd9, 5'd13, 1'b1, 1'b0, 1'b1);
        check("ill_flag", Illegal_o, 1'b1);
        check("ill_rw", RegWrite_o, 1'b0);
        check("ill_result", ALUResult_o, 32'd0);
        check("ill_zero", Zero_o, 1'b1);
        idle(1'b1);

        // Flush with both slots full and a new op arriving.
        step(1'b1, 3'd0, 32'd10, 32'd1, 5'd14, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd20, 32'd2, 5'd15, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd30, 32'd3, 5'd16, 1'b1, 1'b1, 1'b1);
        check("flush_valid", out_valid_o, 1'b0);
        check("flush_ready", in_ready_o, 1'b1);
        repeat (3) idle(1'b1);

        // Randomized traffic.
        corner[0] = 32'h0;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 3000; i++) begin
            ops_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            ops_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if (ops_b[3:0] == 4'h5) ops_b = ops_a;   // exercise equal-operand cases
            step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ops_a, ops_b,
                 5'($urandom), 1'($urandom), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 6);
        end
        repeat (3) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
